// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding, ctrl_state width and default memory timeout for pipe_stall_ctrl
package pipe_ctrl_pkg;
  localparam int STATE_W = 2;
  localparam int DEF_MEM_TIMEOUT = 255;
  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
// Ports: clk, reset_n (async active-low), clr (sync clear, wins over inc), inc, cnt (sticks at all ones)
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: 5-stage pipeline hazard controller (load-use stall, branch flush, memory wait with timeout)
// Optional macro PIPE_STALL_PERF_EN adds saturating perf counters lu_stall_cnt, mem_stall_cnt, flush_cnt.
// Inputs : clk, reset_n (async active-low), id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
//          branch_taken, dmem_req, dmem_ready
// Outputs: pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_err, ctrl_state
//          (combinational from state and inputs)
import pipe_ctrl_pkg::*;
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               id_ex_mem_read,
  input  logic [4:0]         id_ex_rd,
  input  logic [4:0]         if_id_rs1,
  input  logic [4:0]         if_id_rs2,
  input  logic               branch_taken,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               id_ex_bubble,
  output logic               pipe_hold,
  output logic               mem_err,
  output logic [STATE_W-1:0] ctrl_state
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [CNT_W-1:0]   lu_stall_cnt,
  output logic [CNT_W-1:0]   mem_stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW:0] TMO = (TW+1)'(MEM_TIMEOUT);
  state_t state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [TW:0] cnt_inc;
  logic load_use, mem_stall;
  assign load_use = id_ex_mem_read && id_ex_rd != 5'd0 && (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
  assign mem_stall = dmem_req && !dmem_ready;
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign ctrl_state = state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ST_RUN;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // The unused encoding 3 falls into the default branch and behaves as RUN.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pc_write = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold = 1'b0;
    mem_err = 1'b0;
    case (state)
      ST_MEM_WAIT: begin
        pc_write = 1'b0;
        if_id_write = 1'b0;
        pipe_hold = 1'b1;
        // ready beats the timeout; the timeout fires as the count reaches MEM_TIMEOUT so it never wraps
        if (dmem_ready) begin
          state_n = ST_RUN;
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc[TW-1:0];
          state_n = cnt_inc >= TMO ? ST_ERR : ST_MEM_WAIT;
        end
      end
      ST_ERR: begin
        pc_write = 1'b0;
        if_id_write = 1'b0;
        pipe_hold = 1'b1;
        mem_err = 1'b1;
      end
      default: begin
        if (mem_stall) begin
          pc_write = 1'b0;
          if_id_write = 1'b0;
          pipe_hold = 1'b1;
          state_n = ST_MEM_WAIT;
          cnt_n = TW'(1);
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write = 1'b0;
          if_id_write = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
    endcase
  end
`ifdef PIPE_STALL_PERF_EN
  // Event decode from the outputs: bubble without flush is a load-use stall,
  // hold without error is a RUN memory stall or a MEM_WAIT cycle.
  sat_counter #(.WIDTH(CNT_W)) u_lu (
    .clk(clk), .reset_n(reset_n), .clr(1'b0), .inc(id_ex_bubble && !if_id_flush), .cnt(lu_stall_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_mem (
    .clk(clk), .reset_n(reset_n), .clr(1'b0), .inc(pipe_hold && !mem_err), .cnt(mem_stall_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_fl (
    .clk(clk), .reset_n(reset_n), .clr(1'b0), .inc(if_id_flush), .cnt(flush_cnt)
  );
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed self-checking bench for pipe_stall_ctrl (MEM_TIMEOUT=4, CNT_W=2)
module tb_pipe_stall_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  logic id_ex_mem_read, branch_taken, dmem_req, dmem_ready;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_err;
  logic [1:0] ctrl_state;
  int total = 0;
  int bad = 0;
`ifdef PIPE_STALL_PERF_EN
  logic [1:0] lu_c, ms_c, fl_c;
`endif
  pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold), .mem_err(mem_err),
    .ctrl_state(ctrl_state)
`ifdef PIPE_STALL_PERF_EN
    , .lu_stall_cnt(lu_c), .mem_stall_cnt(ms_c), .flush_cnt(fl_c)
`endif
  );
  always #5 clk = ~clk;
  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_err, ctrl_state}
  logic [7:0] obs;
  assign obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_err, ctrl_state};
  localparam logic [7:0] IDLE = 8'b1100_0000;
  localparam logic [7:0] LU   = 8'b0001_0000;
  localparam logic [7:0] FL   = 8'b1111_0000;
  localparam logic [7:0] MS   = 8'b0000_1000;
  localparam logic [7:0] MW   = 8'b0000_1001;
  localparam logic [7:0] ER   = 8'b0000_1110;
  // stimulus word: {mem_read, rd, rs1, rs2, branch, dmem_req, dmem_ready}
  function automatic logic [18:0] st(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                                     input logic [4:0] r2, input logic br, input logic rq, input logic rdy);
    return {mr, rd, r1, r2, br, rq, rdy};
  endfunction
  task automatic drive(input logic [18:0] s);
    {id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2, branch_taken, dmem_req, dmem_ready} = s;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    drive(19'd0);
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    cyc();
  endtask
  task automatic test_reset();
    drive(st(1, 5, 5, 0, 0, 0, 0));
    reset_n = 1'b0;
    drive(19'd0);
    @(negedge clk);
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL reset_in obs=%b exp=%b", obs, IDLE); end
    reset_n = 1'b1;
    cyc();
    @(negedge clk);
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL reset_after obs=%b exp=%b", obs, IDLE); end
    cyc();
  endtask
  task automatic test_load_use();
    logic [18:0] s [8];
    logic [7:0] e [8];
    s = '{st(1, 5, 5, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0), st(1, 5, 0, 5, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0),
          st(1, 0, 0, 0, 0, 0, 0), st(1, 5, 6, 7, 0, 0, 0), st(0, 5, 5, 5, 0, 0, 0), st(1, 31, 3, 31, 0, 0, 0)};
    e = '{LU, IDLE, LU, IDLE, IDLE, IDLE, IDLE, LU};
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      @(negedge clk);
      total++;
      if (obs !== e[i]) begin bad++; $display("FAIL load_use[%0d] obs=%b exp=%b", i, obs, e[i]); end
      cyc();
    end
  endtask
  task automatic test_branch();
    logic [18:0] s [5];
    logic [7:0] e [5];
    s = '{st(1, 5, 5, 0, 1, 0, 0), st(0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 1, 0, 0),
          st(1, 5, 5, 0, 1, 1, 0), st(0, 0, 0, 0, 0, 1, 1)};
    e = '{FL, IDLE, FL, MS, MW};
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      @(negedge clk);
      total++;
      if (obs !== e[i]) begin bad++; $display("FAIL branch[%0d] obs=%b exp=%b", i, obs, e[i]); end
      cyc();
    end
  endtask
  task automatic test_mem_wait();
    logic [18:0] s [6];
    logic [7:0] e [6];
    s = '{st(0, 0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 1, 0), st(1, 5, 5, 0, 1, 1, 0),
          st(0, 0, 0, 0, 0, 1, 1), st(1, 5, 5, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0)};
    e = '{MS, MW, MW, MW, LU, IDLE};
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      @(negedge clk);
      total++;
      if (obs !== e[i]) begin bad++; $display("FAIL mem_wait[%0d] obs=%b exp=%b", i, obs, e[i]); end
      cyc();
    end
  endtask
  task automatic test_ready_at_timeout();
    logic [18:0] s [5];
    logic [7:0] e [5];
    s = '{st(0, 0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 1, 0),
          st(0, 0, 0, 0, 0, 1, 1), st(0, 0, 0, 0, 0, 0, 0)};
    e = '{MS, MW, MW, MW, IDLE};
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      @(negedge clk);
      total++;
      if (obs !== e[i]) begin bad++; $display("FAIL ready_tmo[%0d] obs=%b exp=%b", i, obs, e[i]); end
      cyc();
    end
  endtask
  task automatic test_timeout();
    logic [18:0] s [8];
    logic [7:0] e [8];
    s = '{st(0, 0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 1, 0),
          st(0, 0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 1, 1), st(0, 0, 0, 0, 0, 0, 0), st(1, 5, 5, 0, 1, 0, 0)};
    e = '{MS, MW, MW, MW, ER, ER, ER, ER};
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      @(negedge clk);
      total++;
      if (obs !== e[i]) begin bad++; $display("FAIL timeout[%0d] obs=%b exp=%b", i, obs, e[i]); end
      cyc();
    end
    do_reset();
    @(negedge clk);
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL timeout_reset obs=%b exp=%b", obs, IDLE); end
    cyc();
  endtask
  task automatic test_reset_mid_wait();
    drive(st(0, 0, 0, 0, 0, 1, 0));
    cyc();
    @(negedge clk);
    total++;
    if (obs !== MW) begin bad++; $display("FAIL rst_wait_pre obs=%b exp=%b", obs, MW); end
    drive(19'd0);
    reset_n = 1'b0;
    #1;
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL rst_wait_now obs=%b exp=%b", obs, IDLE); end
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      total++;
      if (obs !== IDLE) begin bad++; $display("FAIL rst_wait_after[%0d] obs=%b exp=%b", i, obs, IDLE); end
    end
    cyc();
  endtask
`ifdef PIPE_STALL_PERF_EN
  task automatic test_perf();
    do_reset();
    #1;
    total++;
    if ({lu_c, ms_c, fl_c} !== 6'd0) begin bad++; $display("FAIL perf_zero obs=%b exp=0", {lu_c, ms_c, fl_c}); end
    for (int i = 0; i < 4; i++) begin
      drive(st(1, 5, 5, 0, 0, 0, 0));
      cyc();
    end
    drive(st(0, 0, 0, 0, 1, 0, 0));
    cyc();
    drive(st(0, 0, 0, 0, 0, 1, 0));
    cyc();
    drive(st(0, 0, 0, 0, 0, 1, 1));
    cyc();
    drive(19'd0);
    cyc();
    total++;
    if ({lu_c, ms_c, fl_c} !== {2'd3, 2'd2, 2'd1})
      begin bad++; $display("FAIL perf_cnt obs=%b exp=%b", {lu_c, ms_c, fl_c}, {2'd3, 2'd2, 2'd1}); end
    do_reset();
    total++;
    if ({lu_c, ms_c, fl_c} !== 6'd0) begin bad++; $display("FAIL perf_clr obs=%b exp=0", {lu_c, ms_c, fl_c}); end
  endtask
`endif
  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_ready_at_timeout();
    test_timeout();
    test_reset_mid_wait();
`ifdef PIPE_STALL_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max MEM_WAIT cycles before error.
REQ-002 SHALL have parameter CNT_W, default 32, perf counter width.
REQ-003 SHALL have one clock and an asynchronous active-low reset; all other ports are synchronous to clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  async active-low reset.
REQ-006 id_ex_mem_read  in  1  EX-stage instr is a load.
REQ-007 id_ex_rd  in  5  EX-stage destination register.
REQ-008 if_id_rs1 / if_id_rs2  in  5 each  ID-stage source registers.
REQ-009 branch_taken  in  1  EX-stage branch/jump resolved taken.
REQ-010 dmem_req  in  1  MEM-stage data access active.
REQ-011 dmem_ready  in  1  data memory completes the access this cycle.
REQ-012 pc_write  out  1  PC update enable.
REQ-013 if_id_write  out  1  IF/ID register enable.
REQ-014 if_id_flush  out  1  clear IF/ID to NOP.
REQ-015 id_ex_bubble  out  1  zero ID/EX control (regWrite=0, memWrite=0).
REQ-016 pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
REQ-017 mem_err  out  1  sticky timeout error.
REQ-018 ctrl_state  out  2  current FSM state.

Function
REQ-019 States: RUN=0, MEM_WAIT=1, ERR=2; code 3 unused, decodes as RUN.
REQ-020 load_use = id_ex_mem_read AND id_ex_rd!=0 AND (id_ex_rd==if_id_rs1 OR id_ex_rd==if_id_rs2).
REQ-021 mem_stall = dmem_req AND NOT dmem_ready.
REQ-022 Outputs are combinational from state and inputs (zero-cycle latency).
REQ-023 Defaults: pc_write=1, if_id_write=1, all others 0.
REQ-024 RUN priority: mem_stall > branch_taken > load_use.
REQ-025 RUN, mem_stall: pc_write=0, if_id_write=0, pipe_hold=1; next state MEM_WAIT; wait counter loads 1.
REQ-026 RUN, branch_taken, no mem_stall: if_id_flush=1, id_ex_bubble=1, pc_write=1; the load_use stall is suppressed.
REQ-027 RUN, load_use only: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle; state stays RUN.
REQ-028 MEM_WAIT: pc_write=0, if_id_write=0, pipe_hold=1; branch_taken and load_use are ignored while frozen.
REQ-029 MEM_WAIT with dmem_ready=1: that cycle remains frozen; next state RUN and the counter clears; held hazards re-evaluate in RUN.
REQ-030 MEM_WAIT without dmem_ready: the counter increments; when the counter reaches MEM_TIMEOUT, next state ERR.
REQ-031 dmem_ready and the timeout in the same cycle: ready wins and next state is RUN.
REQ-032 ERR: mem_err=1, pc_write=0, if_id_write=0, pipe_hold=1; ERR is left only by reset.
REQ-033 The wait counter is ceil(log2(MEM_TIMEOUT+1)) bits and never wraps.

Reset
REQ-034 reset_n low SHALL asynchronously force state RUN, clear the counter and clear mem_err; outputs take their RUN defaults with the inputs idle.
REQ-035 Reset asserted mid-MEM_WAIT or in ERR SHALL abort the wait with no residual stall after deassertion.

Configuration
REQ-036 With PIPE_STALL_PERF_EN defined, the block SHALL add outputs lu_stall_cnt, mem_stall_cnt and flush_cnt (CNT_W each); these are saturating, cleared by reset, and increment on REQ-027, REQ-025/REQ-028 and REQ-026 cycles respectively.
REQ-037 Without PIPE_STALL_PERF_EN, the block SHALL have no counter ports or logic and identical behaviour otherwise.

Structure
REQ-038 Package pipe_ctrl_pkg SHALL hold the state encoding constants, the ctrl_state width and the default MEM_TIMEOUT.
REQ-039 One sub-module, sat_counter (parameter width, inc/clr, saturates at all ones), SHALL be instantiated three times under PIPE_STALL_PERF_EN.

Verification
REQ-040 Load x5, then next instr uses rs1=x5 -> one cycle pc_write=0/id_ex_bubble=1, then normal; the same sequence with rd=x0 -> no stall.
REQ-041 dmem_req=1 with dmem_ready after 3 cycles -> pipe_hold=1 for 4 cycles, ctrl_state 1 then 0.
REQ-042 branch_taken and load_use in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1, no stall cycle.
REQ-043 MEM_TIMEOUT=4 and dmem_ready never asserted -> ERR entered on the 5th frozen cycle, mem_err=1 until reset_n pulse, then RUN.
REQ-044 reset_n asserted during MEM_WAIT -> immediate RUN and defaults; with PIPE_STALL_PERF_EN, counters read 0 and saturate when CNT_W=2 after 3 events.
